// File: rtl/hovalaag_instr_loader.sv
// Assembles six 6-bit pin chunks into 32-bit instructions with a one-deep hold slot.
// Optional checksum checking is enabled by defining HOVALAAG_LOADER_CHECK_EN.
module hovalaag_instr_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  data_in,
    input  logic        data_valid,
    output logic        in_ready,
    input  logic        sync_clear,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [2:0]  chunk_cnt,
    output logic [7:0]  instr_count,
    output logic        err
);

    localparam logic [2:0] LAST_CHUNK = 3'd5;

    logic [5:0]  chunk_reg [0:4];
    logic [1:0]  top_reg;
    logic [2:0]  chunk_cnt_reg, chunk_cnt_next;
    logic        asm_full_reg, asm_full_next;
    logic [31:0] instr_out_reg, instr_out_next;
    logic        instr_valid_reg, instr_valid_next;
    logic [7:0]  instr_count_reg, instr_count_next;
    logic        err_reg, err_next;

    logic        accept;
    logic        last_chunk;
    logic        loadable;
    logic        check_ok;
    logic [29:0] low_word;
    logic [31:0] new_word;
    logic [31:0] held_word;

    assign accept     = data_valid && !asm_full_reg && !sync_clear;
    assign last_chunk = accept && (chunk_cnt_reg == LAST_CHUNK);
    assign loadable   = !instr_valid_reg || instr_ready;
    assign new_word   = {data_in[1:0], low_word};
    assign held_word  = {top_reg, low_word};

    // Chunks 0..4 each own a 6-bit slice; a held word stays put because in_ready is low.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_chunk
            assign low_word[6*gi +: 6] = chunk_reg[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    chunk_reg[gi] <= '0;
                end else if (accept && (chunk_cnt_reg == 3'(gi))) begin
                    chunk_reg[gi] <= data_in;
                end
            end
        end
    endgenerate

`ifdef HOVALAAG_LOADER_CHECK_EN
    logic [3:0] nib_xor;

    always_comb begin
        nib_xor = '0;
        for (int i = 0; i < 8; i++) begin
            nib_xor = nib_xor ^ new_word[4*i +: 4];
        end
    end

    assign check_ok = (data_in[5:2] == nib_xor);
`else
    logic unused_check_nibble;

    assign unused_check_nibble = ^data_in[5:2];
    assign check_ok            = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_reg <= '0;
        end else if (last_chunk && check_ok && !loadable) begin
            top_reg <= data_in[1:0];
        end
    end

    always_comb begin
        chunk_cnt_next   = chunk_cnt_reg;
        asm_full_next    = asm_full_reg;
        instr_out_next   = instr_out_reg;
        instr_valid_next = instr_valid_reg;
        instr_count_next = instr_count_reg;
        err_next         = err_reg;

        if (sync_clear) begin
            chunk_cnt_next = '0;
        end else if (accept) begin
            chunk_cnt_next = last_chunk ? 3'd0 : chunk_cnt_reg + 3'd1;
        end

        if (instr_valid_reg && instr_ready) begin
            instr_valid_next = 1'b0;
            instr_count_next = instr_count_reg + 8'd1;
        end

        // A held word and a fresh chunk 5 never coincide: accept needs !asm_full.
        if (asm_full_reg && loadable) begin
            instr_out_next   = held_word;
            instr_valid_next = 1'b1;
            asm_full_next    = 1'b0;
        end else if (last_chunk) begin
            if (!check_ok) begin
                err_next = 1'b1;
            end else if (loadable) begin
                instr_out_next   = new_word;
                instr_valid_next = 1'b1;
            end else begin
                asm_full_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chunk_cnt_reg   <= '0;
            asm_full_reg    <= 1'b0;
            instr_out_reg   <= '0;
            instr_valid_reg <= 1'b0;
            instr_count_reg <= '0;
            err_reg         <= 1'b0;
        end else begin
            chunk_cnt_reg   <= chunk_cnt_next;
            asm_full_reg    <= asm_full_next;
            instr_out_reg   <= instr_out_next;
            instr_valid_reg <= instr_valid_next;
            instr_count_reg <= instr_count_next;
            err_reg         <= err_next;
        end
    end

    assign in_ready    = !asm_full_reg;
    assign instr_out   = instr_out_reg;
    assign instr_valid = instr_valid_reg;
    assign chunk_cnt   = chunk_cnt_reg;
    assign instr_count = instr_count_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_hovalaag_instr_loader.sv
// Scoreboard bench for hovalaag_instr_loader: the driver queues expected words,
// a negedge monitor pops and compares on every instr_valid && instr_ready handshake.
module tb_hovalaag_instr_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  data_in = '0;
    logic        data_valid = 1'b0;
    logic        in_ready;
    logic        sync_clear = 1'b0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [2:0]  chunk_cnt;
    logic [7:0]  instr_count;
    logic        err;

    int          vec_count  = 0;
    int          miss_count = 0;
    logic [31:0] exp_q [$];
    logic [5:0]  beef_chunks [6] = '{6'h2F, 6'h3B, 6'h1B, 6'h2B, 6'h1E, 6'h03};

    hovalaag_instr_loader dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .in_ready    (in_ready),
        .sync_clear  (sync_clear),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .chunk_cnt   (chunk_cnt),
        .instr_count (instr_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vec_count++;
        if (act !== req) begin
            miss_count++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    function automatic logic [3:0] nib_xor(input logic [31:0] w);
        logic [3:0] x;
        x = '0;
        for (int i = 0; i < 8; i++) x = x ^ w[4*i +: 4];
        return x;
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_chunk(input logic [5:0] c);
        int waitc;
        waitc      = 0;
        data_in    = c;
        data_valid = 1'b1;
        while (!in_ready && waitc < 50) begin
            cycles(1);
            waitc++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        cycles(1);
        data_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [3:0] nib);
        for (int k = 0; k < 5; k++) send_chunk(w[6*k +: 6]);
        send_chunk({nib, w[31:30]});
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                vec_count++;
                miss_count++;
                $display("FAIL deliver: got unexpected 0x%08h, required no delivery", instr_out);
            end else begin
                check("deliver", instr_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;

        // Reset state
        cycles(2);
        rst = 1'b0;
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_out",   instr_out,         32'd0);
        check("rst_chunk_cnt",   32'(chunk_cnt),   32'd0);
        check("rst_instr_count", 32'(instr_count), 32'd0);
        check("rst_err",         32'(err),         32'd0);
        check("rst_in_ready",    32'(in_ready),    32'd1);

        // Basic load from the literal chunk table
        instr_ready = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        for (int k = 0; k < 6; k++) send_chunk(beef_chunks[k]);
        check("basic_valid_hi",  32'(instr_valid), 32'd1);
        check("basic_out",       instr_out,         32'hDEADBEEF);
        cycles(1);
        check("basic_valid_lo",  32'(instr_valid), 32'd0);
        check("basic_count",     32'(instr_count), 32'd1);
        check("basic_err",       32'(err),         32'd0);
        check("basic_chunk_cnt", 32'(chunk_cnt),   32'd0);

        // Backpressure: second word held in assembly
        instr_ready = 1'b0;
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'hCAFEF00D);
        send_word(32'h12345678, nib_xor(32'h12345678));
        send_word(32'hCAFEF00D, nib_xor(32'hCAFEF00D));
        check("bp_in_ready",  32'(in_ready), 32'd0);
        check("bp_out_first", instr_out,      32'h12345678);
        cycles(2);
        check("bp_out_stable", instr_out,      32'h12345678);
        check("bp_chunk_cnt",  32'(chunk_cnt), 32'd0);
        instr_ready = 1'b1;
        cycles(2);
        check("bp_valid_lo",  32'(instr_valid), 32'd0);
        check("bp_count",     32'(instr_count), 32'd3);
        check("bp_in_ready1", 32'(in_ready),    32'd1);

        // sync_clear drops a partial word and beats a simultaneous chunk
        w = 32'h0BADF00D;
        for (int k = 0; k < 3; k++) send_chunk(w[6*k +: 6]);
        check("sc_chunk_cnt3", 32'(chunk_cnt), 32'd3);
        data_in    = w[23:18];
        data_valid = 1'b1;
        sync_clear = 1'b1;
        cycles(1);
        sync_clear = 1'b0;
        data_valid = 1'b0;
        check("sc_chunk_cnt0", 32'(chunk_cnt), 32'd0);
        exp_q.push_back(32'h5A5A1234);
        send_word(32'h5A5A1234, nib_xor(32'h5A5A1234));
        cycles(2);
        check("sc_count", 32'(instr_count), 32'd4);

        // Bad check nibble on 0xDEADBEEF (final chunk 0x07)
`ifdef HOVALAAG_LOADER_CHECK_EN
        for (int k = 0; k < 5; k++) send_chunk(beef_chunks[k]);
        send_chunk(6'h07);
        cycles(2);
        check("ck_err",   32'(err),         32'd1);
        check("ck_count", 32'(instr_count), 32'd4);
        check("ck_valid", 32'(instr_valid), 32'd0);
`else
        exp_q.push_back(32'hDEADBEEF);
        for (int k = 0; k < 5; k++) send_chunk(beef_chunks[k]);
        send_chunk(6'h07);
        cycles(2);
        check("ck_err",   32'(err),         32'd0);
        check("ck_count", 32'(instr_count), 32'd5);
`endif

        // Asynchronous reset between edges with a pending word and a partial word
        instr_ready = 1'b0;
        send_word(32'h11112222, nib_xor(32'h11112222));
        check("ar_pre_valid", 32'(instr_valid), 32'd1);
        w = 32'h33334444;
        for (int k = 0; k < 5; k++) send_chunk(w[6*k +: 6]);
        check("ar_pre_chunk_cnt", 32'(chunk_cnt), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("ar_instr_valid", 32'(instr_valid), 32'd0);
        check("ar_instr_out",   instr_out,         32'd0);
        check("ar_chunk_cnt",   32'(chunk_cnt),   32'd0);
        check("ar_instr_count", 32'(instr_count), 32'd0);
        check("ar_err",         32'(err),         32'd0);
        check("ar_in_ready",    32'(in_ready),    32'd1);
        rst = 1'b0;
        instr_ready = 1'b1;
        exp_q.push_back(32'h87654321);
        send_word(32'h87654321, nib_xor(32'h87654321));
        cycles(2);
        check("ar_fresh_count", 32'(instr_count), 32'd1);

        // Count wrap: 255 more deliveries bring the total to 256
        for (int i = 1; i < 255; i++) begin
            w = 32'h9E3779B9 * 32'(i);
            exp_q.push_back(w);
            send_word(w, nib_xor(w));
        end
        cycles(2);
        check("wrap_count_255", 32'(instr_count), 32'd255);
        exp_q.push_back(32'hFFFFFFFF);
        send_word(32'hFFFFFFFF, nib_xor(32'hFFFFFFFF));
        cycles(2);
        check("wrap_count_0", 32'(instr_count), 32'd0);

        cycles(2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
